gdma_axaddr_gen: RTL
====================

GDMA_AXADDR_GEN -- requirements
Module: gdma_axaddr_gen

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- ADDR_W, 49, AXI address width.
- LEN_W, 32, byte-length input width.
- SIZE_LOG2, 2, log2 of beat bytes; drives axsize.
- MAX_BURST, 256, maximum beats per burst (1..256).
- BOUNDARY_LOG2, 12, no-cross boundary (4 KB).
- MAX_OUTST, 8, maximum bursts issued but not yet completed (1..255).

REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports (name, direction, width, meaning):
- clk, in, 1: sole clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: single-cycle job request.
- start_addr, in, ADDR_W: job byte address.
- length, in, LEN_W: job byte count.
- busy, out, 1: job in progress.
- done, out, 1: one-cycle pulse at job end.
- err_len, out, 1: one-cycle pulse for a zero-beat job.
- cpl, in, 1: one burst completed (response handshake pulse).
- axaddr, out, ADDR_W: burst address.
- axlen, out, 8: beats-1.
- axsize, out, 3: constant SIZE_LOG2.
- axburst, out, 2: constant 2'b01 (INCR).
- axcache, out, 4: constant 4'b0011.
- axlock/axprot/axqos/axregion, out, 1/3/4/4: constant 0.
- axvalid, out, 1: address valid.
- axready, in, 1: address ready.
- outst_cnt, out, 8: bursts issued minus bursts completed.

Function
REQ-003 The FSM SHALL have states IDLE, CALC, ISSUE and DRAIN.
REQ-004 In IDLE, start SHALL latch start_addr with its low SIZE_LOG2 bits forced to 0, and SHALL latch beats = length >> SIZE_LOG2.
- beats==0: pulse err_len and done in the next cycle, and stay in IDLE.
- otherwise: go to CALC.
REQ-005 start SHALL be ignored while busy=1.
- busy = 1 in CALC, ISSUE and DRAIN.
REQ-006 CALC SHALL last exactly 1 cycle and register the first axlen, then enter ISSUE.
- Latency from start to the first axvalid is 2 cycles.
REQ-007 Each burst's beat count SHALL be min(beats remaining, MAX_BURST, beats to next 2^BOUNDARY_LOG2 boundary).
- axlen = that count - 1.
- Arithmetic is in beat units and at least LEN_W bits wide, with no truncation.
REQ-008 axvalid SHALL assert in ISSUE only when outst_cnt < MAX_OUTST.
- Once asserted, axvalid, axaddr and axlen SHALL stay stable until axvalid&&axready.
REQ-009 On each axvalid&&axready:
- axaddr advances by (axlen+1)<<SIZE_LOG2;
- remaining beats decrease by axlen+1;
- the next axlen is registered in the same cycle, so back-to-back bursts need no idle cycle when axready is held high and the outstanding limit allows.
- axvalid next = remaining>0 && outst_cnt_next < MAX_OUTST.
REQ-010 When the handshake retires the last beats, axvalid SHALL drop next cycle and the FSM SHALL enter DRAIN.
REQ-011 outst_cnt SHALL update as follows:
- +1 on handshake; -1 on cpl; unchanged when both occur in the same cycle.
- cpl with outst_cnt==0 and no handshake is ignored (count stays 0).
REQ-012 DRAIN SHALL exit to IDLE when outst_cnt==0 (including the cycle it first reaches 0).
- done pulses one cycle, coincident with the IDLE transition.
- busy drops in the same cycle.
REQ-013 Address arithmetic SHALL wrap modulo 2^ADDR_W without error.
REQ-014 The constant AXI attribute outputs SHALL never change, including during reset.

Reset
REQ-015 When rst=1 at a clock edge, the block SHALL return to IDLE and clear the following regardless of state:
- axvalid=0, busy=0, done=0, err_len=0;
- outst_cnt=0, axlen=0, axaddr=0.
REQ-016 rst mid-job SHALL abandon remaining bursts, even with axvalid high.
- The external interconnect is reset concurrently.
REQ-017 The first start SHALL be accepted in the first cycle after rst deasserts.

Verification (SIZE_LOG2=2, MAX_BURST=256, MAX_OUTST=8 unless noted)
REQ-018 start_addr=0x0, length=8192, axready=1, cpl 4 cycles after each handshake -> 8 bursts, axlen=255, axaddr 0x0,0x400,…,0x1C00, back-to-back, then one done.
REQ-019 start_addr=0xFF0, length=64 -> burst1 0xFF0/axlen=3, burst2 0x1000/axlen=11.
REQ-020 MAX_OUTST=2, length=4096, cpl withheld -> exactly 2 handshakes, axvalid low, outst_cnt=2; one cpl -> third burst issued.
REQ-021 length=3 -> err_len and done pulse, no axvalid, busy stays 0.
REQ-022 cpl coincident with handshake at outst_cnt=3 -> outst_cnt stays 3; start while busy -> no effect.
REQ-023 rst asserted while axvalid=1 and outst_cnt=5 -> next cycle all outputs at reset values; new start works normally.

Source files
------------

// File: rtl/gdma_axaddr_gen.sv
// gdma_axaddr_gen
//   Splits one DMA job (byte address + byte length) into AXI INCR bursts on an
//   address channel. Each burst is capped by the beats left in the job, by
//   MAX_BURST and by the next 2^BOUNDARY_LOG2-byte boundary. At most MAX_OUTST
//   bursts may be issued without a matching completion.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   start               one-cycle job request (ignored while busy)
//   start_addr, length  job byte address and byte count
//   busy                job in progress
//   done                one-cycle pulse at job end
//   err_len             one-cycle pulse when the job holds zero whole beats
//   cpl                 one burst completed
//   axaddr .. axregion  AXI address-channel payload
//   axvalid, axready    AXI address-channel handshake
//   outst_cnt           bursts issued minus bursts completed
module gdma_axaddr_gen #(
    parameter int unsigned ADDR_W        = 49,
    parameter int unsigned LEN_W         = 32,
    parameter int unsigned SIZE_LOG2     = 2,
    parameter int unsigned MAX_BURST     = 256,
    parameter int unsigned BOUNDARY_LOG2 = 12,
    parameter int unsigned MAX_OUTST     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    input  logic              cpl,
    output logic [ADDR_W-1:0] axaddr,
    output logic [7:0]        axlen,
    output logic [2:0]        axsize,
    output logic [1:0]        axburst,
    output logic [3:0]        axcache,
    output logic              axlock,
    output logic [2:0]        axprot,
    output logic [3:0]        axqos,
    output logic [3:0]        axregion,
    output logic              axvalid,
    input  logic              axready,
    output logic [7:0]        outst_cnt
);

    // Beat-unit arithmetic width: wide enough for the job beat count, for a
    // full boundary span and for MAX_BURST, plus one guard bit.
    localparam int unsigned BL  = BOUNDARY_LOG2 - SIZE_LOG2;
    localparam int unsigned CW0 = (LEN_W > BL + 1) ? LEN_W : BL + 1;
    localparam int unsigned CW  = ((CW0 > 9) ? CW0 : 9) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StIssue, StDrain} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     rem_q;
    logic [7:0]        axlen_q;
    logic [7:0]        outst_q;
    logic              axvalid_q;
    logic              done_q;
    logic              err_len_q;

    logic              hs;
    logic [7:0]        outst_nxt;
    logic              slot_free;
    logic [CW-1:0]     burst_cur;
    logic [ADDR_W-1:0] addr_adv;
    logic [CW-1:0]     rem_adv;
    logic [CW-1:0]     calc_rem;
    logic [CW-1:0]     calc_off;
    logic [CW-1:0]     to_bnd;
    logic [CW-1:0]     cnt;
    logic [7:0]        axlen_nxt;
    logic [ADDR_W-1:0] start_aligned;
    logic [CW-1:0]     start_beats;

    always_comb begin
        hs        = axvalid_q & axready;
        outst_nxt = outst_q;
        // A completion with nothing outstanding is dropped.
        if (hs && !cpl) begin
            outst_nxt = outst_q + 8'd1;
        end else if (!hs && cpl && (outst_q != 8'd0)) begin
            outst_nxt = outst_q - 8'd1;
        end
        slot_free = outst_nxt < 8'(MAX_OUTST);

        burst_cur = CW'(axlen_q) + CW'(1);
        addr_adv  = addr_q + (ADDR_W'(burst_cur) << SIZE_LOG2);
        rem_adv   = rem_q - burst_cur;

        // CALC sizes the first burst from the latched job; ISSUE sizes the
        // next burst from the post-handshake address and remainder.
        if (state_q == StCalc) begin
            calc_rem = rem_q;
            calc_off = CW'(addr_q[BOUNDARY_LOG2-1:SIZE_LOG2]);
        end else begin
            calc_rem = rem_adv;
            calc_off = CW'(addr_adv[BOUNDARY_LOG2-1:SIZE_LOG2]);
        end
        to_bnd = (CW'(1) << BL) - calc_off;
        cnt    = calc_rem;
        if (to_bnd < cnt) begin
            cnt = to_bnd;
        end
        if (CW'(MAX_BURST) < cnt) begin
            cnt = CW'(MAX_BURST);
        end
        axlen_nxt = 8'(cnt - CW'(1));

        start_aligned = start_addr & ~((ADDR_W'(1) << SIZE_LOG2) - ADDR_W'(1));
        start_beats   = CW'(length >> SIZE_LOG2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rem_q     <= '0;
            axlen_q   <= '0;
            outst_q   <= '0;
            axvalid_q <= 1'b0;
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            outst_q   <= outst_nxt;
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q <= start_aligned;
                        rem_q  <= start_beats;
                        if (start_beats == '0) begin
                            err_len_q <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    axlen_q   <= axlen_nxt;
                    axvalid_q <= slot_free;
                    state_q   <= StIssue;
                end
                StIssue: begin
                    if (hs) begin
                        addr_q <= addr_adv;
                        rem_q  <= rem_adv;
                        if (rem_adv == '0) begin
                            axvalid_q <= 1'b0;
                            state_q   <= StDrain;
                        end else begin
                            axlen_q   <= axlen_nxt;
                            axvalid_q <= slot_free;
                        end
                    end else if (!axvalid_q) begin
                        // Waiting on the outstanding limit; payload is already set.
                        axvalid_q <= slot_free;
                    end
                end
                StDrain: begin
                    if (outst_q == 8'd0) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err_len   = err_len_q;
    assign axaddr    = addr_q;
    assign axlen     = axlen_q;
    assign axvalid   = axvalid_q;
    assign outst_cnt = outst_q;

    assign axsize   = 3'(SIZE_LOG2);
    assign axburst  = 2'b01;
    assign axcache  = 4'b0011;
    assign axlock   = 1'b0;
    assign axprot   = 3'b000;
    assign axqos    = 4'b0000;
    assign axregion = 4'b0000;

endmodule
